// File: rtl/regloop.sv
// regloop: loop-index register with programmable step, bound and wrap/saturate handling
// Ports:
//   clock, rst                 rising-edge clock, synchronous active-high reset
//   write_en, datain           load dataout from datain (lowest priority)
//   inc_en, dec_en, step       step up/down by step (0 means 1); both together hold
//   lim_en                     load limit from datain, independent of dataout priority
//   dataout, limit             registered index and bound
//   at_limit, at_zero          combinational compares on dataout
//   wrap, ovf                  one-cycle bound-crossing pulse, sticky overflow record
module regloop #(
    parameter int WIDTH    = 16,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             write_en,
    input  logic [WIDTH-1:0] datain,
    input  logic             inc_en,
    input  logic             dec_en,
    input  logic [WIDTH-1:0] step,
    input  logic             lim_en,
    output logic [WIDTH-1:0] dataout,
    output logic [WIDTH-1:0] limit,
    output logic             at_limit,
    output logic             at_zero,
    output logic             wrap,
    output logic             ovf
);
    logic [WIDTH-1:0] data_q, data_d, lim_q, lim_d;
    logic             wrap_q, wrap_d, ovf_q, ovf_d;
    logic [WIDTH:0]   s, up_sum;
    logic             up, dn, ld, up_cross, dn_cross;

    always_comb begin
        s        = {1'b0, step} | (WIDTH+1)'(step == '0);
        up_sum   = {1'b0, data_q} + s;
        up       = inc_en & ~dec_en;
        dn       = dec_en & ~inc_en;
        ld       = write_en & ~inc_en & ~dec_en;
        // sums are compared at WIDTH+1 bits so a carry out counts as a crossing
        up_cross = up_sum > {1'b0, lim_q};
        dn_cross = s > {1'b0, data_q};
        data_d   = up ? (up_cross ? (SAT_MODE ? lim_q : '0) : up_sum[WIDTH-1:0]) :
                   dn ? (dn_cross ? (SAT_MODE ? '0 : lim_q) : data_q - s[WIDTH-1:0]) :
                   ld ? datain : data_q;
        wrap_d   = (up & up_cross) | (dn & dn_cross);
        ovf_d    = wrap_d | (ovf_q & ~ld);
        lim_d    = lim_en ? datain : lim_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            data_q <= '0;
            lim_q  <= '1;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            lim_q  <= lim_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dataout  = data_q;
    assign limit    = lim_q;
    assign at_limit = data_q == lim_q;
    assign at_zero  = data_q == '0;
    assign wrap     = wrap_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_regloop.sv
// tb_regloop: wrap and saturate instances driven in parallel against an integer reference model
module tb_regloop;
    logic        clock = 1'b0;
    logic        rst = 1'b0, write_en = 1'b0, inc_en = 1'b0, dec_en = 1'b0, lim_en = 1'b0;
    logic [15:0] datain = '0, step = '0;
    logic [15:0] dout [2], lim [2];
    logic        atl [2], atz [2], wrp [2], ov [2];
    int          md [2], ml [2], mw [2], mo [2];
    int          total = 0, bad = 0;

    always #5 clock = ~clock;

    regloop #(.WIDTH(16), .SAT_MODE(1'b0)) u_wrap (
        .clock(clock), .rst(rst), .write_en(write_en), .datain(datain), .inc_en(inc_en),
        .dec_en(dec_en), .step(step), .lim_en(lim_en), .dataout(dout[0]), .limit(lim[0]),
        .at_limit(atl[0]), .at_zero(atz[0]), .wrap(wrp[0]), .ovf(ov[0]));
    regloop #(.WIDTH(16), .SAT_MODE(1'b1)) u_sat (
        .clock(clock), .rst(rst), .write_en(write_en), .datain(datain), .inc_en(inc_en),
        .dec_en(dec_en), .step(step), .lim_en(lim_en), .dataout(dout[1]), .limit(lim[1]),
        .at_limit(atl[1]), .at_zero(atz[1]), .wrap(wrp[1]), .ovf(ov[1]));

    task automatic chk(input string tag, input int m, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s[mode%0d] got=%0h exp=%0h", tag, m, got, exp);
        end
    endtask

    task automatic model(input bit r, we, ie, de, le, input int din, st);
        int s, nd, nw;
        s = (st == 0) ? 1 : st;
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                md[m] = 0; ml[m] = 65535; mw[m] = 0; mo[m] = 0;
            end else begin
                nd = md[m];
                nw = 0;
                if (ie && !de) begin
                    if (md[m] + s > ml[m]) begin nd = m ? ml[m] : 0; nw = 1; end
                    else nd = md[m] + s;
                end else if (de && !ie) begin
                    if (s > md[m]) begin nd = m ? 0 : ml[m]; nw = 1; end
                    else nd = md[m] - s;
                end else if (we && !ie && !de) begin
                    nd = din;
                    mo[m] = 0;
                end
                if (nw) mo[m] = 1;
                if (le) ml[m] = din;
                md[m] = nd;
                mw[m] = nw;
            end
        end
    endtask

    task automatic cyc(input bit r, we, ie, de, le, input int din, st);
        rst = r; write_en = we; inc_en = ie; dec_en = de; lim_en = le;
        datain = 16'(din); step = 16'(st);
        @(posedge clock);
        #1;
        model(r, we, ie, de, le, din, st);
        for (int m = 0; m < 2; m++) begin
            chk("dataout", m, 32'(dout[m]), 32'(md[m]));
            chk("limit", m, 32'(lim[m]), 32'(ml[m]));
            chk("at_limit", m, 32'(atl[m]), 32'(md[m] == ml[m]));
            chk("at_zero", m, 32'(atz[m]), 32'(md[m] == 0));
            chk("wrap", m, 32'(wrp[m]), 32'(mw[m]));
            chk("ovf", m, 32'(ov[m]), 32'(mo[m]));
        end
    endtask

    initial begin
        // reset values
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_dout", 0, 32'(dout[0]), 32'h0);
        chk("rst_lim", 0, 32'(lim[0]), 32'hffff);
        chk("rst_atz", 0, 32'(atz[0]), 32'h1);
        chk("rst_atl", 0, 32'(atl[0]), 32'h0);
        // step 0 behaves as 1
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0);
            chk("inc1_dout", 0, 32'(dout[0]), 32'(i));
            chk("inc1_wrap", 0, 32'(wrp[0]), 32'h0);
        end
        // wrap at limit 4, step 2
        cyc(0, 0, 0, 0, 1, 4, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 2); chk("w_d0", 0, 32'(dout[0]), 32'd2);
        cyc(0, 0, 1, 0, 0, 0, 2); chk("w_d1", 0, 32'(dout[0]), 32'd4);
        cyc(0, 0, 1, 0, 0, 0, 2); chk("w_d2", 0, 32'(dout[0]), 32'd0);
        chk("w_pulse", 0, 32'(wrp[0]), 32'h1);
        cyc(0, 0, 1, 0, 0, 0, 2); chk("w_d3", 0, 32'(dout[0]), 32'd2);
        chk("w_pulse_end", 0, 32'(wrp[0]), 32'h0);
        chk("w_ovf", 0, 32'(ov[0]), 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 2); chk("w_ovf_hold", 0, 32'(ov[0]), 32'h1);
        // saturate at limit 4, step 3
        cyc(0, 1, 0, 0, 0, 0, 0); chk("ovf_clr", 1, 32'(ov[1]), 32'h0);
        cyc(0, 0, 1, 0, 0, 0, 3); chk("s_d0", 1, 32'(dout[1]), 32'd3);
        cyc(0, 0, 1, 0, 0, 0, 3); chk("s_d1", 1, 32'(dout[1]), 32'd4);
        chk("s_wrap1", 1, 32'(wrp[1]), 32'h1);
        cyc(0, 0, 1, 0, 0, 0, 3); chk("s_d2", 1, 32'(dout[1]), 32'd4);
        chk("s_wrap2", 1, 32'(wrp[1]), 32'h1);
        // down steps past zero
        cyc(0, 0, 0, 0, 1, 9, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 2);
        chk("dn_wrap", 0, 32'(dout[0]), 32'd9);
        chk("dn_sat", 1, 32'(dout[1]), 32'd0);
        chk("dn_ovf", 0, 32'(ov[0]), 32'h1);
        chk("dn_ovf", 1, 32'(ov[1]), 32'h1);
        // simultaneous events
        cyc(0, 1, 0, 0, 0, 5, 0);
        cyc(0, 1, 1, 0, 0, 7, 1); chk("step_wins", 0, 32'(dout[0]), 32'd6);
        cyc(0, 0, 1, 1, 0, 0, 1); chk("incdec_hold", 0, 32'(dout[0]), 32'd6);
        cyc(1, 1, 1, 1, 1, 7, 1);
        chk("rst_all_dout", 1, 32'(dout[1]), 32'h0);
        chk("rst_all_lim", 1, 32'(lim[1]), 32'hffff);
        // limit load alongside a step uses the old limit
        cyc(0, 1, 0, 0, 0, 3, 0);
        cyc(0, 0, 1, 0, 1, 3, 1);
        chk("ll_dout", 0, 32'(dout[0]), 32'd4);
        chk("ll_lim", 0, 32'(lim[0]), 32'd3);
        cyc(0, 0, 1, 0, 0, 0, 1);
        chk("ll_wrap_d", 0, 32'(dout[0]), 32'd0);
        chk("ll_wrap_p", 0, 32'(wrp[0]), 32'h1);
        chk("ll_sat_d", 1, 32'(dout[1]), 32'd3);
        // randomized traffic, mostly small values so bounds are hit often
        for (int i = 0; i < 400; i++) begin
            int din, st;
            din = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 20));
            st  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 5));
            cyc($urandom_range(0, 60) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, din, st);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
